// File: rtl/simple_bus_arbiter_if.sv
// Request, response and simple-bus signals of simple_bus_arbiter bundled as one interface.
// The arbiter uses the slave modport; the requesters and the bus environment use master.
interface simple_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_op;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [16*NUM_REQ-1:0] req_wr_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_rd_data;
  logic                  bus_valid;
  logic                  bus_op;
  logic [15:0]           bus_addr;
  logic [15:0]           bus_wr_data;
  logic [15:0]           bus_rd_data;
  logic                  busy;

  modport master (
    output req_valid, req_op, req_addr, req_wr_data, bus_rd_data,
    input  req_ready, rsp_valid, rsp_rd_data,
    input  bus_valid, bus_op, bus_addr, bus_wr_data, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wr_data, bus_rd_data,
    output req_ready, rsp_valid, rsp_rd_data,
    output bus_valid, bus_op, bus_addr, bus_wr_data, busy
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one outstanding simple-bus transaction at a time.
// Define SIMPLE_BUS_ARB_PRIO0_EN to make requester 0 always win, with 1..NUM_REQ-1 rotating.
module simple_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                 clk,
  input logic                 reset,
  simple_bus_arbiter_if.slave bus_if
);
  localparam int unsigned   GW = $clog2(NUM_REQ);
  localparam logic [GW:0]   NR = (GW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] cap_idx;
  logic          cap_op;
  logic [2:0]    wait_cnt;

  logic [GW-1:0] grant_idx;
  logic          grant_any;
  logic [GW:0]   sum;
  logic          win_op;
  logic [15:0]   win_addr;
  logic [15:0]   win_wdata;

  // Search starts one past the last winner and wraps modulo NUM_REQ.
  always_comb begin
    sum       = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_grant} + (GW + 1)'(k);
      if (sum >= NR) sum = sum - NR;
`ifdef SIMPLE_BUS_ARB_PRIO0_EN
      if (!grant_any && sum[GW-1:0] != '0 && bus_if.req_valid[sum[GW-1:0]]) begin
`else
      if (!grant_any && bus_if.req_valid[sum[GW-1:0]]) begin
`endif
        grant_any = 1'b1;
        grant_idx = sum[GW-1:0];
      end
    end
`ifdef SIMPLE_BUS_ARB_PRIO0_EN
    if (bus_if.req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end
`endif
  end

  always_comb begin
    win_op    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GW'(i)) begin
        win_op    = bus_if.req_op[i];
        win_addr  = bus_if.req_addr[16*i +: 16];
        win_wdata = bus_if.req_wr_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    bus_if.req_ready = '0;
    if (state == IDLE && grant_any && !reset) bus_if.req_ready[grant_idx] = 1'b1;
  end

  always_comb bus_if.busy = (state != IDLE);

  // Bus and response outputs are loaded on the edge entering ISSUE/RESP, so
  // they hold their values for exactly that state and are zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      last_grant         <= GW'(NUM_REQ - 1);
      cap_idx            <= '0;
      cap_op             <= 1'b0;
      wait_cnt           <= '0;
      bus_if.bus_valid   <= 1'b0;
      bus_if.bus_op      <= 1'b0;
      bus_if.bus_addr    <= '0;
      bus_if.bus_wr_data <= '0;
      bus_if.rsp_valid   <= '0;
      bus_if.rsp_rd_data <= '0;
    end else begin
      bus_if.bus_valid   <= 1'b0;
      bus_if.bus_op      <= 1'b0;
      bus_if.bus_addr    <= '0;
      bus_if.bus_wr_data <= '0;
      bus_if.rsp_valid   <= '0;
      bus_if.rsp_rd_data <= '0;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            cap_idx            <= grant_idx;
            cap_op             <= win_op;
`ifdef SIMPLE_BUS_ARB_PRIO0_EN
            if (grant_idx != '0) last_grant <= grant_idx;
`else
            last_grant         <= grant_idx;
`endif
            bus_if.bus_valid   <= 1'b1;
            bus_if.bus_op      <= win_op;
            bus_if.bus_addr    <= win_addr;
            bus_if.bus_wr_data <= win_op ? win_wdata : '0;
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          if (cap_op) begin
            bus_if.rsp_valid[cap_idx] <= 1'b1;
            state                     <= RESP;
          end else begin
            wait_cnt <= 3'(RD_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            bus_if.rsp_valid[cap_idx] <= 1'b1;
            bus_if.rsp_rd_data        <= bus_if.bus_rd_data;
            state                     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
